// File: rtl/coreabc_iram_param.sv
// Parametrised instruction RAM with hardware fill sequencer, per-word even parity
// and an optional output pipeline stage on the read path.
module coreabc_iram_param #(
  parameter int unsigned        DWIDTH     = 9,
  parameter int unsigned        AWIDTH     = 9,
  parameter int unsigned        DEPTH      = 512,
  parameter logic [DWIDTH-1:0]  FILL_VALUE = '0,
  parameter bit                 AUTOFILL   = 1'b1,
  parameter bit                 OUTREG     = 1'b0
) (
  input  logic              RWCLK,
  input  logic              RESETN,
  input  logic              RENABLE,
  input  logic [AWIDTH-1:0] RADDR,
  output logic [DWIDTH-1:0] RD,
  output logic              RVALID,
  output logic              PERR,
  input  logic [AWIDTH-1:0] INITADDR,
  input  logic              WENABLE,
  input  logic [DWIDTH-1:0] INITDATA,
  input  logic              WPINV,
  input  logic              CLEAR,
  output logic              BUSY,
  output logic              DONE
);

  localparam int unsigned       IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AWIDTH:0]   DEPTH_W = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH-1:0] LAST    = AWIDTH'(DEPTH - 1);

  typedef enum logic {
    ST_READY,
    ST_FILL
  } state_e;

  localparam state_e RESET_STATE = AUTOFILL ? ST_FILL : ST_READY;

  state_e              state_q, state_d;
  logic [AWIDTH-1:0]   cnt_q, cnt_d;
  logic                done_q, done_d;
  logic [DWIDTH-1:0]   rd_q, rd_d;
  logic                perr_q, perr_d;
  logic                rvalid_q, rvalid_d;

  logic [DWIDTH:0]     mem_q [0:DEPTH-1];
  logic                mem_we;
  logic [IW-1:0]       mem_waddr;
  logic [DWIDTH:0]     mem_wdata;
  logic [DWIDTH:0]     rword;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    rd_d      = rd_q;
    perr_d    = perr_q;
    rvalid_d  = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = INITADDR[IW-1:0];
    mem_wdata = {(^INITDATA) ^ WPINV, INITDATA};
    rword     = '0;
    unique case (state_q)
      ST_FILL: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q[IW-1:0];
        mem_wdata = {^FILL_VALUE, FILL_VALUE};
        if (cnt_q == LAST) begin
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_READY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_READY: begin
        // Read sees the array before this edge's write: read-before-write.
        if (RENABLE) begin
          rvalid_d = 1'b1;
          if ({1'b0, RADDR} < DEPTH_W) begin
            rword  = mem_q[RADDR[IW-1:0]];
            rd_d   = rword[DWIDTH-1:0];
            perr_d = rword[DWIDTH] ^ (^rword[DWIDTH-1:0]);
          end else begin
            rd_d   = '0;
            perr_d = 1'b0;
          end
        end
        mem_we = WENABLE && ({1'b0, INITADDR} < DEPTH_W);
        if (CLEAR) begin
          state_d = ST_FILL;
          cnt_d   = '0;
        end
      end
      default: ;
    endcase
    // The array has no reset, so block writes while reset is held.
    mem_we = mem_we & RESETN;
  end

  always_ff @(posedge RWCLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q  <= RESET_STATE;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      rd_q     <= '0;
      perr_q   <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      rd_q     <= rd_d;
      perr_q   <= perr_d;
      rvalid_q <= rvalid_d;
    end
  end

  always_ff @(posedge RWCLK) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign BUSY = (state_q == ST_FILL);
  assign DONE = done_q;

  if (OUTREG) begin : g_outreg
    logic [DWIDTH-1:0] rd_p_q;
    logic              perr_p_q;
    logic              rvalid_p_q;

    always_ff @(posedge RWCLK or negedge RESETN) begin
      if (!RESETN) begin
        rd_p_q     <= '0;
        perr_p_q   <= 1'b0;
        rvalid_p_q <= 1'b0;
      end else begin
        rd_p_q     <= rd_q;
        perr_p_q   <= perr_q;
        rvalid_p_q <= rvalid_q;
      end
    end

    assign RD     = rd_p_q;
    assign PERR   = perr_p_q;
    assign RVALID = rvalid_p_q;
  end else begin : g_direct
    assign RD     = rd_q;
    assign PERR   = perr_q;
    assign RVALID = rvalid_q;
  end

endmodule

// File: tb/tb_coreabc_iram_param.sv
// Bench for coreabc_iram_param: drives an OUTREG=0 and an OUTREG=1 instance with the
// same directed and random stimulus and checks both against a behavioural model.
module tb_coreabc_iram_param;
  localparam int DW  = 9;
  localparam int AW  = 10;
  localparam int DEP = 512;
  localparam logic [DW-1:0] FV = 9'h155;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ren, wen, wpinv, clr;
  logic [AW-1:0] raddr, iaddr;
  logic [DW-1:0] idata;

  logic [DW-1:0] rd0, rd1;
  logic          rv0, rv1, pe0, pe1, busy0, busy1, done0, done1;

  always #5 clk = ~clk;

  coreabc_iram_param #(.DWIDTH(DW), .AWIDTH(AW), .DEPTH(DEP), .FILL_VALUE(FV),
                       .AUTOFILL(1'b1), .OUTREG(1'b0)) u0 (
    .RWCLK(clk), .RESETN(rst_n), .RENABLE(ren), .RADDR(raddr), .RD(rd0),
    .RVALID(rv0), .PERR(pe0), .INITADDR(iaddr), .WENABLE(wen), .INITDATA(idata),
    .WPINV(wpinv), .CLEAR(clr), .BUSY(busy0), .DONE(done0));

  coreabc_iram_param #(.DWIDTH(DW), .AWIDTH(AW), .DEPTH(DEP), .FILL_VALUE(FV),
                       .AUTOFILL(1'b1), .OUTREG(1'b1)) u1 (
    .RWCLK(clk), .RESETN(rst_n), .RENABLE(ren), .RADDR(raddr), .RD(rd1),
    .RVALID(rv1), .PERR(pe1), .INITADDR(iaddr), .WENABLE(wen), .INITDATA(idata),
    .WPINV(wpinv), .CLEAR(clr), .BUSY(busy1), .DONE(done1));

  int checks   = 0;
  int failures = 0;

  // Model: word contents, and whether the stored parity was deliberately corrupted.
  logic [DW-1:0] mdata [DEP];
  bit            mflip [DEP];
  bit            mbusy, mdone;
  int            mcnt;
  logic [DW-1:0] e_rd0, e_rd1;
  bit            e_v0, e_v1, e_p0, e_p1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mbusy = 1'b1; mdone = 1'b0; mcnt = 0;
    e_rd0 = '0; e_rd1 = '0; e_v0 = 1'b0; e_v1 = 1'b0; e_p0 = 1'b0; e_p1 = 1'b0;
  endtask

  task automatic model_edge();
    bit            nv;
    bit            np;
    logic [DW-1:0] nrd;
    nv = 1'b0; nrd = e_rd0; np = e_p0;
    e_v1 = e_v0; e_rd1 = e_rd0; e_p1 = e_p0;
    mdone = 1'b0;
    if (mbusy) begin
      mdata[mcnt] = FV;
      mflip[mcnt] = 1'b0;
      if (mcnt == DEP - 1) begin
        mbusy = 1'b0; mdone = 1'b1; mcnt = 0;
      end else begin
        mcnt++;
      end
    end else begin
      if (ren) begin
        nv = 1'b1;
        if (int'(raddr) < DEP) begin
          nrd = mdata[raddr[8:0]]; np = mflip[raddr[8:0]];
        end else begin
          nrd = '0; np = 1'b0;
        end
      end
      if (wen && int'(iaddr) < DEP) begin
        mdata[iaddr[8:0]] = idata;
        mflip[iaddr[8:0]] = wpinv;
      end
      if (clr) begin
        mbusy = 1'b1; mcnt = 0;
      end
    end
    e_v0 = nv; e_rd0 = nrd; e_p0 = np;
  endtask

  task automatic check_all();
    chk("busy0", busy0, mbusy);
    chk("busy1", busy1, mbusy);
    chk("done0", done0, mdone);
    chk("done1", done1, mdone);
    chk("rvalid0", rv0, e_v0);
    chk("rvalid1", rv1, e_v1);
    chk("rd0", rd0, e_rd0);
    chk("rd1", rd1, e_rd1);
    if (e_v0) chk("perr0", pe0, e_p0);
    if (e_v1) chk("perr1", pe1, e_p1);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    ren = 1'b0; wen = 1'b0; clr = 1'b0; wpinv = 1'b0;
  endtask

  task automatic rd(input int a);
    idle(); ren = 1'b1; raddr = AW'(a);
    tick();
    ren = 1'b0;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d, input bit p);
    idle(); wen = 1'b1; iaddr = AW'(a); idata = d; wpinv = p;
    tick();
    idle();
  endtask

  task automatic randomize_inputs(input int clr_odds);
    ren   = 1'($urandom % 2);
    raddr = AW'($urandom_range(0, 599));
    wen   = 1'($urandom % 2);
    iaddr = AW'($urandom_range(0, 599));
    idata = DW'($urandom);
    wpinv = ($urandom % 4) == 0;
    clr   = (clr_odds > 0) && (($urandom % clr_odds) == 0);
  endtask

  task automatic count_fill(input string tag);
    int n = 0;
    while (done0 !== 1'b1 && n < 600) begin
      tick();
      n++;
    end
    chk(tag, n, DEP);
  endtask

  task automatic reset_now(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk({tag, "_rd"}, rd0, 0);
    chk({tag, "_rvalid"}, rv0, 0);
    chk({tag, "_busy"}, busy0, 1);
    chk({tag, "_done"}, done0, 0);
    check_all();
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; raddr = '0; iaddr = '0; idata = '0;
    idle();
    for (int i = 0; i < DEP; i++) begin
      mdata[i] = '0; mflip[i] = 1'b0;
    end
    #7;
    reset_now("reset");
    count_fill("fill_len_autofill");
    tick();

    rd(0);   chk("fill_rd0", rd0, FV);
    rd(255); chk("fill_rd255", rd0, FV);
    rd(511); chk("fill_rd511", rd0, FV); chk("fill_perr511", pe0, 0);

    wr(7, 9'h1A5, 1'b0);
    rd(7);
    chk("rd7_direct", rd0, 9'h1A5);
    chk("rd7_rvalid_direct", rv0, 1);
    chk("rd7_rvalid_pipe_early", rv1, 0);
    idle(); tick();
    chk("rd7_pipe", rd1, 9'h1A5);
    chk("rd7_rvalid_pipe", rv1, 1);

    wr(9, 9'h003, 1'b1); rd(9); chk("perr_inv", pe0, 1); chk("perr_inv_rd", rd0, 9'h003);
    wr(9, 9'h003, 1'b0); rd(9); chk("perr_fixed", pe0, 0);

    wr(3, 9'h011, 1'b0);
    idle(); ren = 1'b1; raddr = 10'd3; wen = 1'b1; iaddr = 10'd3; idata = 9'h0FF;
    tick();
    chk("rbw_old", rd0, 9'h011);
    rd(3); chk("rbw_new", rd0, 9'h0FF);

    rd(600); chk("oob_rd", rd0, 0); chk("oob_rvalid", rv0, 1);
    wr(600, 9'h1FF, 1'b0); rd(88); chk("oob_wr_dropped", rd0, FV);

    for (int i = 0; i < 400; i++) begin
      randomize_inputs(64);
      tick();
    end
    idle();
    for (int i = 0; i < 600 && mbusy; i++) tick();
    tick();

    idle(); clr = 1'b1; wen = 1'b1; iaddr = 10'd5; idata = 9'h0AA; ren = 1'b1; raddr = 10'd5;
    tick();
    chk("clr_read_completes", rv0, 1);
    for (int n = 0; n < 600 && done0 !== 1'b1; n++) begin
      randomize_inputs(3);
      tick();
      chk("busy_no_rvalid", rv0, 0);
    end
    idle();
    tick();
    for (int a = 0; a < DEP; a++) begin
      rd(a);
      chk("after_clear", rd0, FV);
    end

    idle(); clr = 1'b1; tick(); idle();
    for (int i = 0; i < 100; i++) tick();
    reset_now("midfill_reset");
    count_fill("fill_len_restart");
    tick();
    for (int i = 0; i < 50; i++) begin
      idle(); ren = 1'b1; raddr = AW'($urandom_range(0, 599));
      tick();
    end
    idle(); tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
